// File: rtl/trap_ctrl_if.sv
// Core-side bundle for the trap controller: retire info, CSR access and redirect/halt.
// TRAP_CTRL_COUNT_EN adds the trap_count observation signal.
interface trap_ctrl_if;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        inst_valid;
   logic        illegal;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] mepc;
   logic [31:0] mcause;
`ifdef TRAP_CTRL_COUNT_EN
   logic [31:0] trap_count;

   modport master (
      output pc, instruction, inst_valid, illegal, csr_we, csr_addr, csr_wdata,
      input  csr_rdata, stall, redirect_valid, redirect_pc, halt, mepc, mcause, trap_count
   );

   modport slave (
      input  pc, instruction, inst_valid, illegal, csr_we, csr_addr, csr_wdata,
      output csr_rdata, stall, redirect_valid, redirect_pc, halt, mepc, mcause, trap_count
   );
`else
   modport master (
      output pc, instruction, inst_valid, illegal, csr_we, csr_addr, csr_wdata,
      input  csr_rdata, stall, redirect_valid, redirect_pc, halt, mepc, mcause
   );

   modport slave (
      input  pc, instruction, inst_valid, illegal, csr_we, csr_addr, csr_wdata,
      output csr_rdata, stall, redirect_valid, redirect_pc, halt, mepc, mcause
   );
`endif
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns mstatus/mtvec/mepc/mcause, sequences trap entry,
// mret return and ebreak halt. Define TRAP_CTRL_COUNT_EN for the saturating trap counter.
//
// state | meaning
// IDLE  | classify retiring instruction, accept CSR writes
// SAVE  | commit latched pc/cause into mepc/mcause, stack MIE
// JUMP  | redirect pulse to mtvec
// RET   | redirect pulse to mepc, unstack MIE
// HALT  | ebreak taken, frozen until reset
module trap_ctrl #(
   parameter logic [31:0] MTVEC_RESET       = 32'h8000_0000,
   parameter logic        MSTATUS_MIE_RESET = 1'b0
) (
   input logic        clk,
   input logic        rst,
   trap_ctrl_if.slave bus
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MHPM3   = 12'hB03;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_BREAK   = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_JUMP,
      ST_RET,
      ST_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        halt_q, halt_d;
   logic [31:0] lat_pc_q, lat_pc_d;
   logic [31:0] lat_cause_q, lat_cause_d;

   logic        cls_trap;
   logic        cls_ebreak;
   logic        cls_mret;
   logic [31:0] trap_cause;

   always_comb begin
      cls_trap   = 1'b0;
      cls_ebreak = 1'b0;
      cls_mret   = 1'b0;
      trap_cause = '0;
      if (state_q == ST_IDLE && bus.inst_valid) begin
         if (bus.illegal) begin
            cls_trap   = 1'b1;
            trap_cause = CAUSE_ILLEGAL;
         end else if (bus.instruction == INST_EBREAK) begin
            cls_ebreak = 1'b1;
         end else if (bus.instruction == INST_ECALL) begin
            cls_trap   = 1'b1;
            trap_cause = CAUSE_ECALL;
         end else if (bus.instruction == INST_MRET) begin
            cls_mret = 1'b1;
         end
      end
   end

   // JUMP and RET are the redirect cycles, so the core is released there.
   assign bus.stall = (state_q == ST_SAVE) || (state_q == ST_HALT) ||
                      cls_trap || cls_ebreak || cls_mret;

   always_comb begin
      state_d          = state_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mtvec_d          = mtvec_q;
      mie_d            = mie_q;
      mpie_d           = mpie_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      halt_d           = halt_q;
      lat_pc_d         = lat_pc_q;
      lat_cause_d      = lat_cause_q;
      case (state_q)
         ST_IDLE: begin
            if (cls_trap) begin
               state_d     = ST_SAVE;
               lat_pc_d    = bus.pc;
               lat_cause_d = trap_cause;
            end else if (cls_ebreak) begin
               state_d  = ST_HALT;
               mepc_d   = bus.pc;
               mcause_d = CAUSE_BREAK;
               halt_d   = 1'b1;
            end else begin
               if (cls_mret) begin
                  state_d          = ST_RET;
                  redirect_valid_d = 1'b1;
                  redirect_pc_d    = {mepc_q[31:2], 2'b00};
               end
               // mret has already consumed the old mepc, so a racing mepc write is dropped.
               if (bus.csr_we && !(cls_mret && bus.csr_addr == ADDR_MEPC)) begin
                  case (bus.csr_addr)
                     ADDR_MSTATUS: begin
                        mie_d  = bus.csr_wdata[3];
                        mpie_d = bus.csr_wdata[7];
                     end
                     ADDR_MTVEC:  mtvec_d  = {bus.csr_wdata[31:2], 2'b00};
                     ADDR_MEPC:   mepc_d   = bus.csr_wdata;
                     ADDR_MCAUSE: mcause_d = bus.csr_wdata;
                     default: ;
                  endcase
               end
            end
         end
         ST_SAVE: begin
            state_d          = ST_JUMP;
            mepc_d           = lat_pc_q;
            mcause_d         = lat_cause_q;
            mpie_d           = mie_q;
            mie_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = {mtvec_q[31:2], 2'b00};
         end
         ST_JUMP: begin
            state_d = ST_IDLE;
         end
         ST_RET: begin
            state_d = ST_IDLE;
            mie_d   = mpie_q;
            mpie_d  = 1'b1;
         end
         ST_HALT: begin
            state_d = ST_HALT;
            halt_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef TRAP_CTRL_COUNT_EN
   logic [31:0] trap_count_q, trap_count_d;

   always_comb begin
      trap_count_d = trap_count_q;
      if ((cls_trap || cls_ebreak) && trap_count_q != 32'hFFFF_FFFF) begin
         trap_count_d = trap_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trap_count_q <= '0;
      end else begin
         trap_count_q <= trap_count_d;
      end
   end

   assign bus.trap_count = trap_count_q;
`endif

   always_comb begin
      bus.csr_rdata = '0;
      case (bus.csr_addr)
         ADDR_MSTATUS: bus.csr_rdata = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
         ADDR_MTVEC:   bus.csr_rdata = mtvec_q;
         ADDR_MEPC:    bus.csr_rdata = mepc_q;
         ADDR_MCAUSE:  bus.csr_rdata = mcause_q;
`ifdef TRAP_CTRL_COUNT_EN
         ADDR_MHPM3:   bus.csr_rdata = trap_count_q;
`else
         ADDR_MHPM3:   bus.csr_rdata = '0;
`endif
         default:      bus.csr_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         mepc_q           <= '0;
         mcause_q         <= '0;
         mtvec_q          <= MTVEC_RESET;
         mie_q            <= MSTATUS_MIE_RESET;
         mpie_q           <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         halt_q           <= 1'b0;
         lat_pc_q         <= '0;
         lat_cause_q      <= '0;
      end else begin
         state_q          <= state_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mtvec_q          <= mtvec_d;
         mie_q            <= mie_d;
         mpie_q           <= mpie_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         halt_q           <= halt_d;
         lat_pc_q         <= lat_pc_d;
         lat_cause_q      <= lat_cause_d;
      end
   end

   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.halt           = halt_q;
   assign bus.mepc           = mepc_q;
   assign bus.mcause         = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: CSR vector table, directed trap/mret/ebreak
// sequences and randomized traffic against a timeline-based reference model.
module tb_trap_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic clk;
   logic rst;
   trap_ctrl_if bus ();

   trap_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc_n   = 0;

   // Reference model: architectural CSRs plus a timeline of scheduled events.
   logic [31:0] m_mepc, m_mcause, m_mtvec, m_count;
   logic        m_mie, m_mpie, m_halt;
   int          m_free_at, m_stall_until, m_redir_at, m_commit_at, m_ret_at;
   logic [31:0] m_redir_pc, m_pend_pc, m_pend_cause;

   logic        s_stall, s_rv, s_halt;
   logic [31:0] s_rpc, s_mepc, s_mcause, s_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
   endtask

   task automatic m_reset();
      m_mepc = '0; m_mcause = '0; m_mtvec = 32'h8000_0000; m_count = '0;
      m_mie = 1'b0; m_mpie = 1'b0; m_halt = 1'b0;
      m_free_at = 0; m_stall_until = -10; m_redir_at = -10; m_commit_at = -10; m_ret_at = -10;
      m_redir_pc = '0; m_pend_pc = '0; m_pend_cause = '0;
      cyc_n = 0;
   endtask

   // 0 none, 1 trap (illegal/ecall), 2 ebreak, 3 mret
   function automatic int m_classify(input logic v, input logic ill, input logic [31:0] instr);
      if (m_halt || cyc_n < m_free_at || !v) return 0;
      if (ill) return 1;
      if (instr == EBREAK) return 2;
      if (instr == ECALL) return 1;
      if (instr == MRET) return 3;
      return 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
`ifdef TRAP_CTRL_COUNT_EN
         12'hB03: return m_count;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [31:0] wd);
      case (a)
         12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
         12'h305: m_mtvec = {wd[31:2], 2'b00};
         12'h341: m_mepc = wd;
         12'h342: m_mcause = wd;
         default: ;
      endcase
   endtask

   task automatic m_advance(input int kind, input logic [31:0] pc, input logic ill,
                            input logic we, input logic [11:0] a, input logic [31:0] wd);
      if (cyc_n == m_commit_at) begin
         m_mepc = m_pend_pc; m_mcause = m_pend_cause; m_mpie = m_mie; m_mie = 1'b0;
      end
      if (cyc_n == m_ret_at) begin
         m_mie = m_mpie; m_mpie = 1'b1;
      end
      if (kind == 1) begin
         m_pend_pc = pc; m_pend_cause = ill ? 32'd2 : 32'd11;
         m_commit_at = cyc_n + 1; m_stall_until = cyc_n + 1;
         m_redir_at = cyc_n + 2; m_redir_pc = {m_mtvec[31:2], 2'b00};
         m_free_at = cyc_n + 3;
         if (m_count != 32'hFFFF_FFFF) m_count++;
      end else if (kind == 2) begin
         m_mepc = pc; m_mcause = 32'd3; m_halt = 1'b1;
         if (m_count != 32'hFFFF_FFFF) m_count++;
      end else if (kind == 3) begin
         m_redir_at = cyc_n + 1; m_redir_pc = {m_mepc[31:2], 2'b00};
         m_ret_at = cyc_n + 1; m_free_at = cyc_n + 2;
         if (we && a != 12'h341) m_write(a, wd);
      end else if (!m_halt && cyc_n >= m_free_at && we) begin
         m_write(a, wd);
      end
      cyc_n++;
   endtask

   task automatic run_cycle(input logic [31:0] pc, input logic [31:0] instr, input logic v,
                            input logic ill, input logic we, input logic [11:0] a,
                            input logic [31:0] wd);
      int kind;
      bus.pc = pc; bus.instruction = instr; bus.inst_valid = v; bus.illegal = ill;
      bus.csr_we = we; bus.csr_addr = a; bus.csr_wdata = wd;
      kind = m_classify(v, ill, instr);
      @(negedge clk);
      s_stall = bus.stall; s_rv = bus.redirect_valid; s_rpc = bus.redirect_pc;
      s_halt = bus.halt; s_mepc = bus.mepc; s_mcause = bus.mcause; s_rdata = bus.csr_rdata;
      chk("stall", {31'b0, s_stall}, {31'b0, (m_halt || cyc_n <= m_stall_until || kind != 0)});
      chk("redirect_valid", {31'b0, s_rv}, {31'b0, (cyc_n == m_redir_at)});
      if (cyc_n == m_redir_at) chk("redirect_pc", s_rpc, m_redir_pc);
      chk("halt", {31'b0, s_halt}, {31'b0, m_halt});
      chk("mepc", s_mepc, m_mepc);
      chk("mcause", s_mcause, m_mcause);
      chk("csr_rdata", s_rdata, m_read(a));
`ifdef TRAP_CTRL_COUNT_EN
      chk("trap_count", bus.trap_count, m_count);
`endif
      m_advance(kind, pc, ill, we, a, wd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic [11:0] a);
      run_cycle(32'h0, NOP, 1'b0, 1'b0, 1'b0, a, 32'h0);
   endtask

   task automatic do_reset();
      bus.inst_valid = 1'b0; bus.illegal = 1'b0; bus.csr_we = 1'b0;
      bus.csr_addr = 12'h305; bus.pc = '0; bus.instruction = NOP; bus.csr_wdata = '0;
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'b0, bus.stall}, 32'h0);
      chk("rst_halt", {31'b0, bus.halt}, 32'h0);
      chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
      chk("rst_mepc", bus.mepc, 32'h0);
      chk("rst_mcause", bus.mcause, 32'h0);
      chk("rst_mtvec", bus.csr_rdata, 32'h8000_0000);
`ifdef TRAP_CTRL_COUNT_EN
      chk("rst_trap_count", bus.trap_count, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_reset();
   endtask

   typedef struct {
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } csr_vec_t;

   csr_vec_t vecs[10];

   initial begin
      vecs[0] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      vecs[1] = '{12'h305, 32'h8000_0203, 32'h8000_0200};
      vecs[2] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
      vecs[3] = '{12'h300, 32'h0000_0008, 32'h0000_0008};
      vecs[4] = '{12'h300, 32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{12'h341, 32'h1234_5679, 32'h1234_5679};
      vecs[6] = '{12'h342, 32'h8000_000B, 32'h8000_000B};
      vecs[7] = '{12'h340, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[8] = '{12'hB03, 32'h0000_0005, 32'h0000_0000};
      vecs[9] = '{12'h001, 32'h5555_5555, 32'h0000_0000};

      rst = 1'b1;
      bus.inst_valid = 1'b0; bus.illegal = 1'b0; bus.csr_we = 1'b0;
      bus.csr_addr = 12'h0; bus.pc = '0; bus.instruction = NOP; bus.csr_wdata = '0;
      #3;
      do_reset();

      // reset state readback
      idle_cycle(12'h305);
      chk("reset_mtvec_read", s_rdata, 32'h8000_0000);
      chk("reset_stall", {31'b0, s_stall}, 32'h0);

      // CSR write/readback table
      foreach (vecs[i]) begin
         run_cycle(32'h0, NOP, 1'b0, 1'b0, 1'b1, vecs[i].addr, vecs[i].wdata);
         idle_cycle(vecs[i].addr);
         chk($sformatf("csr_vec%0d", i), s_rdata, vecs[i].exp);
      end

      // ecall at 0x8000_0010
      do_reset();
      run_cycle(32'h8000_0010, ECALL, 1'b1, 1'b0, 1'b0, 12'h305, 32'h0);
      chk("ecall_stall_n", {31'b0, s_stall}, 32'h1);
      idle_cycle(12'h305);
      chk("ecall_stall_n1", {31'b0, s_stall}, 32'h1);
      idle_cycle(12'h305);
      chk("ecall_redirect", {31'b0, s_rv}, 32'h1);
      chk("ecall_redirect_pc", s_rpc, 32'h8000_0000);
      chk("ecall_stall_n2", {31'b0, s_stall}, 32'h0);
      chk("ecall_mepc", s_mepc, 32'h8000_0010);
      chk("ecall_mcause", s_mcause, 32'd11);
      idle_cycle(12'h305);
      chk("ecall_pulse_end", {31'b0, s_rv}, 32'h0);

      // illegal with modified mtvec and MIE=1
      run_cycle(32'h0, NOP, 1'b0, 1'b0, 1'b1, 12'h305, 32'h8000_0203);
      idle_cycle(12'h305);
      chk("mtvec_masked", s_rdata, 32'h8000_0200);
      run_cycle(32'h0, NOP, 1'b0, 1'b0, 1'b1, 12'h300, 32'h0000_0008);
      idle_cycle(12'h300);
      chk("mie_set", s_rdata, 32'h0000_0008);
      run_cycle(32'h8000_0040, NOP, 1'b1, 1'b1, 1'b0, 12'h300, 32'h0);
      idle_cycle(12'h300);
      idle_cycle(12'h300);
      chk("ill_redirect", {31'b0, s_rv}, 32'h1);
      chk("ill_redirect_pc", s_rpc, 32'h8000_0200);
      chk("ill_mcause", s_mcause, 32'd2);
      chk("ill_mstatus", s_rdata, 32'h0000_0080);

      // mret back to the trapping pc
      run_cycle(32'h8000_0200, MRET, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0);
      chk("mret_stall", {31'b0, s_stall}, 32'h1);
      idle_cycle(12'h300);
      chk("mret_redirect", {31'b0, s_rv}, 32'h1);
      chk("mret_redirect_pc", s_rpc, 32'h8000_0040);
      chk("mret_stall_release", {31'b0, s_stall}, 32'h0);
      idle_cycle(12'h300);
      chk("mret_mstatus", s_rdata, 32'h0000_0088);

      // ecall racing an mtvec write
      do_reset();
      run_cycle(32'h8000_0100, ECALL, 1'b1, 1'b0, 1'b1, 12'h305, 32'h1234_5678);
      idle_cycle(12'h305);
      idle_cycle(12'h305);
      chk("race_redirect_pc", s_rpc, 32'h8000_0000);
      chk("race_mtvec", s_rdata, 32'h8000_0000);
`ifdef TRAP_CTRL_COUNT_EN
      chk("race_trap_count", bus.trap_count, 32'h1);
`endif

      // ebreak halts until reset
      run_cycle(32'h8000_0080, EBREAK, 1'b1, 1'b0, 1'b0, 12'h342, 32'h0);
      chk("ebreak_stall", {31'b0, s_stall}, 32'h1);
      for (int k = 0; k < 5; k++) begin
         run_cycle(32'h8000_0084, ECALL, 1'b1, 1'b0, 1'b1, 12'h342, 32'hFFFF_FFFF);
         chk("halt_sticky", {31'b0, s_halt}, 32'h1);
      end
      chk("halt_mcause", s_mcause, 32'd3);
      chk("halt_mepc", s_mepc, 32'h8000_0080);
      do_reset();
      idle_cycle(12'h305);
      chk("halt_cleared", {31'b0, s_halt}, 32'h0);

      // randomized traffic
      begin
         int halted_for;
         halted_for = 0;
         for (int n = 0; n < 4000; n++) begin
            logic [31:0] pc, instr, wd;
            logic        v, ill, we;
            logic [11:0] a;
            int          r;
            pc  = $urandom;
            r   = int'($urandom_range(0, 15));
            if (r < 3) instr = ECALL;
            else if (r < 6) instr = MRET;
            else if (r == 6 && $urandom_range(0, 15) == 0) instr = EBREAK;
            else if (r < 10) instr = NOP;
            else instr = $urandom;
            v   = ($urandom_range(0, 1) == 1);
            ill = ($urandom_range(0, 7) == 0);
            we  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
               0: a = 12'h300;
               1: a = 12'h305;
               2: a = 12'h341;
               3: a = 12'h342;
               4: a = 12'hB03;
               default: a = 12'($urandom);
            endcase
            wd = $urandom;
            run_cycle(pc, instr, v, ill, we, a, wd);
            if (m_halt) halted_for++;
            if (halted_for > 6 || $urandom_range(0, 199) == 0) begin
               halted_for = 0;
               do_reset();
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
